// File: rtl/subtractor.sv
// ============================================================================
//  Module      : subtractor
//  Description : Registered WIDTH-bit ripple-borrow subtractor, D = A - B - bin,
//                with the borrow-out of every bit position captured alongside.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] b
);

    // w_chain[i] is the borrow into bit i; w_chain[0] is the external borrow-in.
    logic [WIDTH:0]   w_chain;
    logic [WIDTH-1:0] w_diff_d;
    logic [WIDTH-1:0] w_borrow_d;
    logic [WIDTH-1:0] r_diff_q;
    logic [WIDTH-1:0] r_borrow_q;

    assign w_chain[0] = bin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            logic w_axb;
            assign w_axb         = A[i] ^ B[i];
            assign w_diff_d[i]   = w_axb ^ w_chain[i];
            assign w_borrow_d[i] = (~A[i] & B[i]) | (~w_axb & w_chain[i]);
            assign w_chain[i+1]  = w_borrow_d[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff_q   <= '0;
            r_borrow_q <= '0;
        end else begin
            r_diff_q   <= w_diff_d;
            r_borrow_q <= w_borrow_d;
        end
    end

    assign D = r_diff_q;
    assign b = r_borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_subtractor.sv
// ============================================================================
//  Module      : tb_subtractor
//  Description : Self-checking bench for subtractor (WIDTH=4), vector table plus
//                exhaustive sweep and mid-stream reset, scoreboard-compared.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] bb;
        logic       bi;
        logic       rs;
        logic [3:0] ed;
        logic [3:0] eb;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] ed;
        logic [3:0] eb;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .bin(bin),
        .D  (D),
        .b  (b)
    );

    // Reference borrow: b[i] set when the low i+1 bits of A are below B + bin.
    function automatic logic [3:0] ref_borrow(input logic [3:0] a, input logic [3:0] bb,
                                              input logic bi);
        logic [3:0] r;
        logic [4:0] mask;
        logic [4:0] lhs;
        logic [4:0] rhs;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            mask = (5'd1 << (i + 1)) - 5'd1;
            lhs  = {1'b0, a} & mask;
            rhs  = ({1'b0, bb} & mask) + {4'd0, bi};
            r[i] = (lhs < rhs);
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_diff(input logic [3:0] a, input logic [3:0] bb,
                                            input logic bi);
        int v;
        v = int'(a) - int'(bb) - int'(bi);
        return v[3:0];
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry for D=%h b=%b", D, b);
        end else begin
            e = sb.pop_front();
            checks++;
            if (D !== e.ed) begin
                errors++;
                $display("FAIL %s D: got %h expected %h", e.name, D, e.ed);
            end
            checks++;
            if (b !== e.eb) begin
                errors++;
                $display("FAIL %s b: got %b expected %b", e.name, b, e.eb);
            end
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] bb, input logic bi,
                         input logic rs, input logic [3:0] ed, input logic [3:0] eb,
                         input string name);
        exp_t e;
        @(negedge clk);
        A   = a;
        B   = bb;
        bin = bi;
        rst = rs;
        e.ed = ed;
        e.eb = eb;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic apply_model(input logic [3:0] a, input logic [3:0] bb, input logic bi,
                               input logic rs, input string name);
        if (rs)
            apply(a, bb, bi, rs, 4'h0, 4'h0, name);
        else
            apply(a, bb, bi, rs, ref_diff(a, bb, bi), ref_borrow(a, bb, bi), name);
    endtask

    initial begin
        rst = 1'b1;
        A   = '0;
        B   = '0;
        bin = 1'b0;

        vecs.push_back('{4'h7, 4'h2, 1'b1, 1'b1, 4'h0, 4'h0,    "reset_edge1"});
        vecs.push_back('{4'h7, 4'h2, 1'b1, 1'b1, 4'h0, 4'h0,    "reset_edge2"});
        vecs.push_back('{4'h7, 4'h2, 1'b1, 1'b0, 4'h4, 4'h0,    "post_reset"});
        vecs.push_back('{4'h5, 4'h3, 1'b0, 1'b0, 4'h2, 4'b0010, "no_uflow_5m3"});
        vecs.push_back('{4'h9, 4'h0, 1'b0, 1'b0, 4'h9, 4'h0,    "no_uflow_9m0"});
        vecs.push_back('{4'h3, 4'h5, 1'b0, 1'b0, 4'hE, 4'b1100, "uflow_3m5"});
        vecs.push_back('{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 4'b1111, "uflow_0m0b1"});
        vecs.push_back('{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 4'b1111, "ripple_FmFb1"});
        vecs.push_back('{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0,    "ripple_FmFb0"});
        vecs.push_back('{4'hA, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0,    "equal_AmA"});
        vecs.push_back('{4'h8, 4'h1, 1'b0, 1'b0, 4'h7, 4'b0111, "borrow_8m1"});

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].a, vecs[i].bb, vecs[i].bi, vecs[i].rs,
                  vecs[i].ed, vecs[i].eb, vecs[i].name);

        for (int x = 0; x < 512; x++)
            apply_model(x[8:5], x[4:1], x[0], 1'b0, "exhaustive");

        // Mid-stream reset: changing inputs, one reset edge, then normal results resume.
        apply_model(4'h6, 4'h9, 1'b0, 1'b0, "mid_pre1");
        apply_model(4'hC, 4'h3, 1'b1, 1'b0, "mid_pre2");
        apply_model(4'h2, 4'hB, 1'b1, 1'b1, "mid_reset");
        apply_model(4'h4, 4'h7, 1'b0, 1'b0, "mid_resume1");
        apply_model(4'hE, 4'h1, 1'b1, 1'b0, "mid_resume2");
        for (int k = 0; k < 8; k++)
            apply_model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 1'b0, "random");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
